// File: rtl/mem_access_seq.sv
// MEM-stage memory access sequencer.
// Runs one access at a time over a valid/ready request port with a separate
// response strobe. The hazard unit is stalled while an access is pending.
// Load results are sign/zero-extended before they go to WB.
// An access that never gets a response is completed by a timeout.
module mem_access_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req_MEM,
  input  logic [3:0]  wr_en_MEM,
  input  logic [2:0]  load_type_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  input  logic        bubbleM,
  output logic        stall_mem,
  output logic [31:0] rdata_WB,
  output logic        rdata_valid,
  output logic        err_timeout,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;

  // Extracts the addressed byte/half of the word and extends it.
  // The low offset bit is ignored for halfwords; misaligned halves are not trapped.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  ltype,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (ltype)
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'h000000, b};
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'h0000, h};
      default: r = word;   // LW, NOREGWRITE and the unused codes 6/7
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  ltype_q, ltype_d;
  logic        is_load_q, is_load_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        rvalid_q;
  logic        req_valid_q;

  logic        acc_s;
  logic        timeout_hit_s;

  assign acc_s = rd_req_MEM | (|wr_en_MEM);

  // A zero timeout disables the forced completion entirely.
  assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));

  // Next-state, access latching, counter, and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ltype_d   = ltype_q;
    is_load_d = is_load_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (acc_s) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          ltype_d   = load_type_MEM;
          // A store with a stray read request stays a store.
          is_load_d = rd_req_MEM & ~(|wr_en_MEM);
          we_d      = wr_en_MEM;
          addr_d    = addr_MEM;
          wdata_d   = wdata_MEM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rsp_valid) begin
          state_d = S_DONE;
          if (is_load_q) begin
            rdata_d = load_extend(mem_rsp_data, ltype_q, addr_q[1:0]);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_hit_s) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (!bubbleM) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched access and registered outputs; reset aborts any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ltype_q     <= 3'd0;
      is_load_q   <= 1'b0;
      we_q        <= 4'd0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ltype_q     <= ltype_d;
      is_load_q   <= is_load_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rvalid_q    <= (state_d == S_DONE) & is_load_d;
      req_valid_q <= (state_d == S_REQ);
    end
  end

  // Stall covers the IDLE cycle in which an access appears, so no extra cycle is lost.
  assign stall_mem     = ((state_q == S_IDLE) & acc_s) | (state_q == S_REQ) | (state_q == S_WAIT);
  assign rdata_WB      = rdata_q;
  assign rdata_valid   = rvalid_q;
  assign err_timeout   = err_q;
  assign mem_req_valid = req_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wdata     = wdata_q;

endmodule
